// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed display scan controller.
// A character is a 5-bit code plus a parity bit; odd total parity is valid.
package display_pkg;

    localparam int CODE_W = 5;
    localparam int SEG_W  = 7;

    localparam logic [CODE_W-1:0] BLANK_CODE = 5'b00000;
    localparam logic              BLANK_PAR  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              par;
    } char_t;

    localparam char_t BLANK_CHAR = '{code: BLANK_CODE, par: BLANK_PAR};

endpackage

// File: rtl/display_dwell_timer.sv
// Dwell timer: counts 0..DIV-1 while run is high and flags the last cycle.
// Dropping run restarts the count so every digit gets a full dwell.
module display_dwell_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = run && (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller for one shared Display decoder: double-buffered characters,
// one digit per dwell slot with a blank guard cycle, sticky per-digit parity errors.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [2:0]          wr_idx,
    input  logic [CODE_W-1:0]   wr_code,
    input  logic                wr_par,
    input  logic                commit,
    input  logic                err_clr,
    output logic [CODE_W-1:0]   E,
    output logic                P,
    input  logic [SEG_W-1:0]    seg_in,
    input  logic                valid,
    output logic [SEG_W-1:0]    seg,
    output logic [N_DIGITS-1:0] an,
    output logic [N_DIGITS-1:0] err,
    output logic                busy,
    output logic                frame_done
);

    localparam int IDX_W = $clog2(N_DIGITS);

    scan_state_e state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_nxt, load_idx;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [CODE_W-1:0]   e_q, e_d;
    logic                p_q, p_d;
    logic                busy_q, busy_d;
    logic [N_DIGITS-1:0] err_q, err_d, err_set, wr_hit;
    char_t [N_DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
    char_t               load_char;
    logic                expire, swap;

    display_dwell_timer #(.DIV(DIV)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .run    (state_q == SHOW),
        .expire (expire)
    );

    assign frame_done = (state_q == BLANK) && (idx_q == IDX_W'(N_DIGITS - 1));
    assign swap       = busy_q && (frame_done || state_q == IDLE);
    assign busy_d     = swap ? 1'b0 : (busy_q | commit);

    // Out-of-range indices match no digit, so such writes simply vanish.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        assign wr_hit[gi]   = wr_en && (wr_idx == 3'(gi));
        assign shadow_d[gi] = wr_hit[gi] ? char_t'({wr_code, wr_par}) : shadow_q[gi];
        assign active_d[gi] = swap ? shadow_q[gi] : active_q[gi];
        assign err_set[gi]  = expire && !valid && (idx_q == IDX_W'(gi));
        assign err_d[gi]    = err_set[gi] | (err_q[gi] & ~err_clr);
    end

    // The digit loaded at a swap edge must already come from the new copy.
    assign idx_nxt   = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    assign load_idx  = (state_q == BLANK) ? idx_nxt : '0;
    assign load_char = swap ? shadow_q[load_idx] : active_q[load_idx];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        an_d    = an_q;
        e_d     = e_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                an_d = '0;
                if (enable) begin
                    state_d = SHOW;
                    idx_d   = '0;
                    an_d    = N_DIGITS'(1);
                    e_d     = load_char.code;
                    p_d     = load_char.par;
                end
            end
            SHOW: begin
                if (expire) begin
                    state_d = BLANK;
                    an_d    = '0;
                end
            end
            BLANK: begin
                state_d = SHOW;
                idx_d   = idx_nxt;
                an_d    = N_DIGITS'(1) << idx_nxt;
                e_d     = load_char.code;
                p_d     = load_char.par;
            end
            default: begin
                state_d = IDLE;
                an_d    = '0;
            end
        endcase
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            an_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            an_q     <= '0;
            e_q      <= BLANK_CODE;
            p_q      <= BLANK_PAR;
            busy_q   <= 1'b0;
            err_q    <= '0;
            shadow_q <= {N_DIGITS{BLANK_CHAR}};
            active_q <= {N_DIGITS{BLANK_CHAR}};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            e_q      <= e_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign E    = e_q;
    assign P    = p_q;
    assign an   = an_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign seg  = ((state_q == SHOW) && valid) ? seg_in : '0;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with a behavioural Display decoder
// (odd total parity = valid, segments = {2'b01, code}).
module tb_display_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst, enable, wr_en, wr_par, commit, err_clr;
    logic [2:0] wr_idx;
    logic [4:0] wr_code, E;
    logic       P, valid, busy, frame_done;
    logic [6:0] seg_in, seg;
    logic [3:0] an, err;

    always #5 clk = ~clk;

    // Display decoder model; invalid codes still drive segments so gating is visible.
    assign valid  = ^{E, P};
    assign seg_in = valid ? {2'b01, E} : 7'h7F;

    display_scan_ctrl #(.N_DIGITS(N), .DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_code    (wr_code),
        .wr_par     (wr_par),
        .commit     (commit),
        .err_clr    (err_clr),
        .E          (E),
        .P          (P),
        .seg_in     (seg_in),
        .valid      (valid),
        .seg        (seg),
        .an         (an),
        .err        (err),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [3:0] an;
        logic [4:0] e;
        logic       p;
        logic [6:0] seg;
        logic       fd;
        logic       ep_chk;
    } rec_t;

    rec_t sb[$];
    rec_t mr;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_on  = 1'b0;
    int   cur     = 0;

    function automatic logic [6:0] exp_seg(input logic [4:0] c, input logic p);
        return (^{c, p}) ? {2'b01, c} : 7'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_rec(input logic [3:0] a, input logic [4:0] c, input logic p,
                            input logic [6:0] s, input logic fd, input logic ep);
        rec_t r;
        r.an = a; r.e = c; r.p = p; r.seg = s; r.fd = fd; r.ep_chk = ep;
        sb.push_back(r);
    endtask

    // One full frame: DIV show cycles per digit, then a blank that holds E/P.
    task automatic push_frame(input logic [19:0] codes, input logic [3:0] pars);
        for (int d = 0; d < N; d++) begin
            for (int k = 0; k < DIV; k++)
                push_rec(4'(1 << d), codes[d*5 +: 5], pars[d], exp_seg(codes[d*5 +: 5], pars[d]), 1'b0, 1'b1);
            push_rec(4'b0000, codes[d*5 +: 5], pars[d], 7'h00, (d == N - 1), 1'b1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got output an=%b with no expected entry", an);
            end else begin
                mr = sb.pop_front();
                $display("[MON] t=%0t an=%b E=%h P=%b seg=%h fd=%b", $time, an, E, P, seg, frame_done);
                chk("an", 32'(an), 32'(mr.an));
                chk("seg", 32'(seg), 32'(mr.seg));
                chk("frame_done", 32'(frame_done), 32'(mr.fd));
                if (mr.ep_chk) begin
                    chk("E", 32'(E), 32'(mr.e));
                    chk("P", 32'(P), 32'(mr.p));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int k);
        repeat (k - cur) @(posedge clk);
        #1;
        cur = k;
    endtask

    task automatic wr(input logic [2:0] i, input logic [4:0] c, input logic p);
        wr_en = 1'b1; wr_idx = i; wr_code = c; wr_par = p;
    endtask

    task automatic start_scan();
        enable = 1'b1;
        tick();
        mon_on = 1'b1;
        cur    = 1;
    endtask

    task automatic stop_scan();
        enable = 1'b0;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        #1;
        mon_on = 1'b0;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d expected entries never produced", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_an"}, 32'(an), 32'h0);
        chk({tag, "_seg"}, 32'(seg), 32'h0);
        chk({tag, "_E"}, 32'(E), 32'h0);
        chk({tag, "_P"}, 32'(P), 32'h1);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_code = '0;
        wr_par = 1'b0; commit = 1'b0; err_clr = 1'b0;
        repeat (3) tick();

        // 1: reset with enable held high
        enable = 1'b1;
        tick();
        rst = 1'b0; enable = 1'b0;
        check_reset_state("reset");
        tick();
        chk("idle_an", 32'(an), 32'h0);

        // 2: fill shadow, commit, scan one frame
        wr(0, 5'b00001, 0); tick();
        wr(1, 5'b00010, 0); tick();
        wr(2, 5'b00100, 0); tick();
        wr(3, 5'b01000, 0); commit = 1'b1; tick();
        wr_en = 1'b0; commit = 1'b0;
        chk("busy_after_commit", 32'(busy), 32'h1);
        push_frame({5'b01000, 5'b00100, 5'b00010, 5'b00001}, 4'b0000);
        start_scan();
        chk("busy_after_swap", 32'(busy), 32'h0);
        drain();
        chk("err_clean_frame", 32'(err), 32'h0);
        stop_scan();

        // 3: parity error on digit 2, clear, then set beats clear
        wr(2, 5'b00011, 0); commit = 1'b1; tick();
        wr_en = 1'b0; commit = 1'b0;
        chk("busy_idle_commit", 32'(busy), 32'h1);
        tick();
        chk("busy_idle_swap", 32'(busy), 32'h0);
        push_frame({5'b01000, 5'b00011, 5'b00010, 5'b00001}, 4'b0000);
        start_scan();
        drain();
        chk("err_digit2", 32'(err), 32'h4);
        stop_scan();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'h0);
        push_frame({5'b01000, 5'b00011, 5'b00010, 5'b00001}, 4'b0000);
        start_scan();
        goto(14); err_clr = 1'b1;
        goto(15); err_clr = 1'b0;
        chk("err_set_wins", 32'(err), 32'h4);
        drain();
        stop_scan();

        // 4: commit at digit 1, swap only at frame end
        push_frame({5'b01000, 5'b00011, 5'b00010, 5'b00001}, 4'b0000);
        push_frame({5'b11111, 5'b00111, 5'b10001, 5'b10000}, 4'b0010);
        start_scan();
        goto(6);  wr(0, 5'b10000, 0);
        goto(7);  wr(1, 5'b10001, 1);
        goto(8);  wr(2, 5'b00111, 0);
        goto(9);  wr(3, 5'b11111, 0); commit = 1'b1;
        goto(10); wr_en = 1'b0; commit = 1'b0;
        chk("busy_mid_frame", 32'(busy), 32'h1);
        goto(11); commit = 1'b1;
        goto(12); commit = 1'b0;
        goto(20); wr(3, 5'b01010, 1);
        goto(21); wr_en = 1'b0;
        chk("busy_cleared_by_swap", 32'(busy), 32'h0);
        drain();
        stop_scan();

        // 5: disable during SHOW(2), restart at digit 0, then reset drops a pending commit
        for (int d = 0; d < 2; d++) begin
            logic [4:0] c;
            logic       p;
            c = (d == 0) ? 5'b10000 : 5'b10001;
            p = (d == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < DIV; k++) push_rec(4'(1 << d), c, p, exp_seg(c, p), 1'b0, 1'b1);
            push_rec(4'b0000, c, p, 7'h00, 1'b0, 1'b1);
        end
        push_rec(4'b0100, 5'b00111, 1'b0, exp_seg(5'b00111, 1'b0), 1'b0, 1'b1);
        push_rec(4'b0000, 5'b00000, 1'b0, 7'h00, 1'b0, 1'b0);
        push_frame({5'b11111, 5'b00111, 5'b10001, 5'b10000}, 4'b0010);
        start_scan();
        goto(11); enable = 1'b0;
        goto(12); enable = 1'b1;
        drain();
        commit = 1'b1; tick(); commit = 1'b0;
        chk("busy_before_rst", 32'(busy), 32'h1);
        chk("err_before_rst", 32'(err), 32'h4);
        rst = 1'b1; tick();
        rst = 1'b0; enable = 1'b0;
        check_reset_state("midframe_rst");
        push_frame({5'b00000, 5'b00000, 5'b00000, 5'b00000}, 4'b1111);
        start_scan();
        drain();
        chk("busy_commit_lost", 32'(busy), 32'h0);
        stop_scan();

        // 6: out-of-range write indices never reach the shadow copy
        wr(1, 5'b00001, 0); tick();
        wr(4, 5'b11111, 0); tick();
        wr(5, 5'b11111, 0); tick();
        wr(6, 5'b11111, 0); tick();
        wr(7, 5'b11111, 0); commit = 1'b1; tick();
        wr_en = 1'b0; commit = 1'b0;
        push_frame({5'b00000, 5'b00000, 5'b00001, 5'b00000}, 4'b1101);
        start_scan();
        drain();
        stop_scan();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
